// File: rtl/max7219_pkg.sv
// Shared types and constants for the MAX7219 serial write engine.
// Register addresses follow the MAX7219 register map.
package max7219_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        LATCH = 2'd3
    } state_e;

    localparam int FRAME_W = 16;

    localparam logic [3:0] REG_NOOP         = 4'h0;
    localparam logic [3:0] REG_DIGIT0       = 4'h1;
    localparam logic [3:0] REG_DIGIT1       = 4'h2;
    localparam logic [3:0] REG_DIGIT2       = 4'h3;
    localparam logic [3:0] REG_DIGIT3       = 4'h4;
    localparam logic [3:0] REG_DIGIT4       = 4'h5;
    localparam logic [3:0] REG_DIGIT5       = 4'h6;
    localparam logic [3:0] REG_DIGIT6       = 4'h7;
    localparam logic [3:0] REG_DIGIT7       = 4'h8;
    localparam logic [3:0] REG_DECODE_MODE  = 4'h9;
    localparam logic [3:0] REG_INTENSITY    = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
    localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

    // The top nibble of every frame is don't-care to the chip; send zeros.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] addr,
                                                      input logic [7:0] data);
        return {4'b0000, addr, data};
    endfunction

endpackage

// File: rtl/max7219_driver.sv
// Shifts one 16-bit MAX7219 frame out on DIN/CLK/LOAD per accepted request,
// MSB first, two system clocks per serial bit, then latches it with a LOAD rise.
module max7219_driver
    import max7219_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_stb,
    output logic       o_busy,
    output logic       o_ack,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_serial_din,
    output logic       o_serial_dout,
    output logic       o_serial_load,
    output logic       o_serial_clk
);

    state_e               state_r;
    logic [FRAME_W-1:0]   shift_r;
    logic [3:0]           bit_cnt_r;
    logic                 phase_r;
    logic                 busy_r;
    logic                 ack_r;
    logic                 dout_r;
    logic                 load_r;
    logic                 sclk_r;

    // DOUT of the chip is reserved for a future daisy-chain readback.
    logic                 unused_din_s;
    assign unused_din_s = i_serial_din;

    // Frame sequencer: phase 0 presents a bit with sclk low, phase 1 raises sclk.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            bit_cnt_r <= 4'd0;
            phase_r   <= 1'b0;
            busy_r    <= 1'b0;
            ack_r     <= 1'b0;
            dout_r    <= 1'b0;
            load_r    <= 1'b1;
            sclk_r    <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // busy drops one cycle after LATCH, so back-to-back accepts are 36 cycles apart
                    if (busy_r) begin
                        busy_r <= 1'b0;
                    end else if (i_stb) begin
                        busy_r    <= 1'b1;
                        ack_r     <= 1'b1;
                        shift_r   <= make_frame(i_addr, i_data);
                        bit_cnt_r <= 4'd0;
                        phase_r   <= 1'b0;
                        state_r   <= SHIFT;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!phase_r) begin
                        load_r  <= 1'b0;
                        sclk_r  <= 1'b0;
                        dout_r  <= shift_r[FRAME_W-1];
                        phase_r <= 1'b1;
                    end else begin
                        sclk_r    <= 1'b1;
                        shift_r   <= {shift_r[FRAME_W-2:0], 1'b0};
                        phase_r   <= 1'b0;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd15) begin
                            state_r <= HOLD;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end
                end
                HOLD: begin
                    sclk_r  <= 1'b0;
                    dout_r  <= 1'b0;
                    state_r <= LATCH;
                end
                LATCH: begin
                    load_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    dout_r  <= 1'b0;
                    load_r  <= 1'b1;
                    sclk_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = busy_r;
    assign o_ack         = ack_r;
    assign o_serial_dout = dout_r;
    assign o_serial_load = load_r;
    assign o_serial_clk  = sclk_r;

endmodule

// File: tb/tb_max7219_driver.sv
// Scoreboard bench: a serial-line monitor rebuilds frames like the MAX7219 does
// and checks them, plus timing and Code-B digit decode, against queued expectations.
module tb_max7219_driver;
    import max7219_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_stb = 1'b0;
    logic [3:0] i_addr = 4'h0;
    logic [7:0] i_data = 8'h00;
    logic       i_serial_din = 1'b0;
    logic       o_busy, o_ack, o_serial_dout, o_serial_load, o_serial_clk;

    max7219_driver dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_stb         (i_stb),
        .o_busy        (o_busy),
        .o_ack         (o_ack),
        .i_addr        (i_addr),
        .i_data        (i_data),
        .i_serial_din  (i_serial_din),
        .o_serial_dout (o_serial_dout),
        .o_serial_load (o_serial_load),
        .o_serial_clk  (o_serial_clk)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  chip_regs [16];
    int          ack_count = 0;
    int          frames_latched = 0;
    bit          mon_en = 1'b0;
    bit          abort_pending = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // MAX7219 Code-B font for 0..9 (bits DP A B C D E F G)
    function automatic logic [7:0] code_b(input logic [3:0] v);
        case (v)
            4'd0: return 8'h7E;  4'd1: return 8'h30;  4'd2: return 8'h6D;
            4'd3: return 8'h79;  4'd4: return 8'h33;  4'd5: return 8'h5B;
            4'd6: return 8'h5F;  4'd7: return 8'h70;  4'd8: return 8'h7F;
            4'd9: return 8'h7B;  default: return 8'h00;
        endcase
    endfunction

    function automatic int seg_to_bcd(input logic [7:0] seg);
        for (int v = 0; v < 10; v++)
            if (code_b(4'(v)) == (seg & 8'h7F)) return v;
        return -1;
    endfunction

    // What the chip drives on the segments of digit d
    function automatic logic [7:0] digit_segs(input int d);
        logic [7:0] dm;
        logic [7:0] raw;
        dm  = chip_regs[9];
        raw = chip_regs[d + 1];
        if (dm[d]) return code_b(raw[3:0]);
        return raw;
    endfunction

    // Monitor: behaves like the chip's shift register and LOAD latch.
    initial begin
        logic [15:0] sh;
        logic [15:0] exp_frame;
        int          nb;
        int          ack_cyc;
        logic        p_sclk, p_load, p_busy, p_ack, p_dout;
        bit          abort;
        sh = 16'h0; nb = 0; ack_cyc = 0;
        p_sclk = 1'b0; p_load = 1'b1; p_busy = 1'b0; p_ack = 1'b0; p_dout = 1'b0;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                abort = abort_pending;
                if (o_ack) begin
                    check("ack_width", int'(p_ack), 0);
                    ack_count++;
                    ack_cyc = cyc;
                    nb = 0;
                end
                if (!o_busy)
                    check("idle_lines", int'({o_serial_load, o_serial_clk, o_serial_dout, o_ack}), 8);
                if (o_serial_clk && !p_sclk) begin
                    check("dout_stable", int'(o_serial_dout), int'(p_dout));
                    sh = {sh[14:0], o_serial_dout};
                    nb++;
                end
                if (p_busy && !o_busy && !abort)
                    check("busy_len", cyc - ack_cyc, 35);
                if (o_serial_load && !p_load) begin
                    if (abort) begin
                        check("abort_partial", int'(nb < 16), 1);
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        abort_pending = 1'b0;
                    end else begin
                        check("load_time", cyc - ack_cyc, 34);
                        check("sclk_rises", nb, 16);
                        check("frame_expected", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            exp_frame = exp_q.pop_front();
                            check("frame", int'(sh), int'(exp_frame));
                            chip_regs[sh[11:8]] = sh[7:0];
                            frames_latched++;
                        end
                    end
                end
            end
            p_sclk = o_serial_clk; p_load = o_serial_load; p_busy = o_busy;
            p_ack = o_ack; p_dout = o_serial_dout;
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (o_busy && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        check("busy_timeout", int'(o_busy), 0);
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge i_clk);
        wait_idle();
        i_stb = 1'b1; i_addr = a; i_data = d;
        exp_q.push_back({4'h0, a, d});
        @(negedge i_clk);
        check("ack_on_accept", int'({o_ack, o_busy}), 3);
        i_stb = 1'b0;
        i_addr = 4'($urandom);
        i_data = 8'($urandom);
        @(negedge i_clk);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        for (int i = 0; i < 16; i++) chip_regs[i] = 8'h00;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_outputs", int'({o_serial_load, o_serial_clk, o_serial_dout, o_busy, o_ack}), 16);
        i_reset = 1'b0;
        mon_en = 1'b1;

        write_reg(REG_DECODE_MODE, 8'hFF);
        check("single_write_acks", ack_count, 1);
        check("single_write_frames", frames_latched, 1);

        write_reg(REG_INTENSITY, 8'h07);
        write_reg(REG_SCAN_LIMIT, 8'h05);
        write_reg(REG_SHUTDOWN, 8'h01);
        for (int i = 0; i < 6; i++) write_reg(4'(i + 1), 8'(i));
        for (int i = 0; i < 6; i++) check("digit_decode", seg_to_bcd(digit_segs(i)), i);
        for (int i = 0; i < 4; i++) write_reg(4'(i + 1), 8'(i + 6));
        for (int i = 0; i < 4; i++) check("digit_rewrite", seg_to_bcd(digit_segs(i)), i + 6);
        check("intensity", int'(chip_regs[10]), 7);
        check("scan_limit", int'(chip_regs[11]), 5);

        // stb held high across frames: exactly two accepts in 40 cycles
        @(negedge i_clk);
        a0 = ack_count;
        i_stb = 1'b1; i_addr = REG_INTENSITY; i_data = 8'h03;
        exp_q.push_back(16'h0A03);
        exp_q.push_back(16'h0A03);
        repeat (40) @(negedge i_clk);
        i_stb = 1'b0;
        wait_idle();
        check("held_stb_acks", ack_count - a0, 2);
        check("held_intensity", int'(chip_regs[10]), 3);

        // stb pulsed mid-frame must be ignored
        @(negedge i_clk);
        a0 = ack_count;
        i_stb = 1'b1; i_addr = 4'h1; i_data = 8'h04;
        exp_q.push_back(16'h0104);
        @(negedge i_clk);
        i_stb = 1'b0;
        repeat (9) @(negedge i_clk);
        i_stb = 1'b1; i_addr = 4'h2; i_data = 8'h09;
        @(negedge i_clk);
        i_stb = 1'b0;
        wait_idle();
        repeat (3) @(negedge i_clk);
        check("busy_stb_ignored", ack_count - a0, 1);
        check("digit0_after_pulse", seg_to_bcd(digit_segs(0)), 4);
        check("digit1_untouched", seg_to_bcd(digit_segs(1)), 7);

        // reset mid-frame, then a clean write
        @(negedge i_clk);
        i_stb = 1'b1; i_addr = 4'h3; i_data = 8'h55;
        exp_q.push_back(16'h0355);
        @(negedge i_clk);
        i_stb = 1'b0;
        repeat (13) @(negedge i_clk);
        abort_pending = 1'b1;
        i_reset = 1'b1;
        @(negedge i_clk);
        check("midframe_reset", int'({o_serial_load, o_serial_clk, o_serial_dout, o_busy, o_ack}), 16);
        i_reset = 1'b0;
        write_reg(4'h3, 8'h02);
        check("digit2_after_reset", seg_to_bcd(digit_segs(2)), 2);

        // random register writes with random gaps
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 4)) @(negedge i_clk);
            write_reg(4'($urandom_range(0, 15)), 8'($urandom));
        end

        repeat (5) @(negedge i_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
